// File: rtl/ul_bfp_compress_array.sv
// rtl/ul_bfp_compress_array.sv - per-PRB block-floating-point compressor for NUM_ANT antenna lanes
// Ping-pong PRB buffer, per-lane shared exponent, rounded/saturated mantissas, metadata aligned per PRB.
module ul_bfp_compress_array #(
    parameter int NUM_ANT    = 4,
    parameter int IW         = 16,
    parameter int OW         = 7,
    parameter int RE_PER_PRB = 12,
    parameter int SHW        = 4,
    parameter int META_W     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_vld,
    input  logic                    i_sop,
    input  logic                    i_eop,
    input  logic                    i_comp_en,
    input  logic [NUM_ANT*2*IW-1:0] i_din,
    input  logic [META_W-1:0]       i_meta,
    output logic                    o_vld,
    output logic                    o_sop,
    output logic                    o_eop,
    output logic [NUM_ANT*2*OW-1:0] o_dout,
    output logic [NUM_ANT*SHW-1:0]  o_shift,
    output logic [META_W-1:0]       o_meta,
    output logic                    o_err
);
    localparam int AW = (RE_PER_PRB > 1) ? $clog2(RE_PER_PRB) : 1;
    localparam int MW = IW - 1;
    localparam int DW = NUM_ANT * 2 * IW;
    localparam logic [AW-1:0] LAST = AW'(RE_PER_PRB - 1);
    localparam logic signed [IW:0] Y_MAX = (IW+1)'((2 ** (OW - 1)) - 1);
    localparam logic signed [IW:0] Y_MIN = (IW+1)'(-(2 ** (OW - 1)));

    // One's-complement magnitude: the most negative input folds onto the largest positive value.
    function automatic logic [MW-1:0] mag(input logic [IW-1:0] x);
        return x[IW-1] ? ~x[MW-1:0] : x[MW-1:0];
    endfunction

    function automatic logic [SHW-1:0] shift_of(input logic [MW-1:0] m);
        int len, s;
        len = 0;
        for (int b = 0; b < MW; b++) if (m[b]) len = b + 1;
        s = (len + 1 > OW) ? len + 1 - OW : 0;
        if (s > 2 ** SHW - 1) s = 2 ** SHW - 1;
        return SHW'(s);
    endfunction

    function automatic logic [OW-1:0] quant(input logic [IW-1:0] x, input logic [SHW-1:0] s);
        logic signed [IW:0] xe, rnd, y;
        xe  = $signed({x[IW-1], x});
        rnd = (IW+1)'(1) << (s - 1'b1);
        y   = (s == '0) ? xe : ((xe + rnd) >>> s);
        if (y > Y_MAX) y = Y_MAX;
        else if (y < Y_MIN) y = Y_MIN;
        return y[OW-1:0];
    endfunction

    logic [DW-1:0]                mem [2][RE_PER_PRB];
    logic                         cap_open, cap_bank, cap_en;
    logic [AW-1:0]                re_cnt, wr_idx, rd_idx;
    logic [META_W-1:0]            cap_meta, calc_meta;
    logic [NUM_ANT-1:0][MW-1:0]   run_m, new_m, calc_m;
    logic [NUM_ANT-1:0][SHW-1:0]  shift_nxt;
    logic                         calc_pend, calc_bank, calc_eop, calc_en;
    logic                         drain_act, drain_bank, drain_eop, err;
    logic                         open_now, last_re, eop_err, sop_err, orphan;
    logic [DW-1:0]                rd_word;

    always_comb begin
        open_now = i_vld & (i_sop | cap_open);
        wr_idx   = i_sop ? '0 : re_cnt;
        last_re  = open_now & (wr_idx == LAST);
        eop_err  = open_now & i_eop & ~last_re;
        sop_err  = i_vld & i_sop & cap_open;
        orphan   = i_vld & ~open_now;
        for (int a = 0; a < NUM_ANT; a++) begin
            new_m[a] = i_sop ? '0 : run_m[a];
            if (mag(i_din[a*2*IW + IW +: IW]) > new_m[a]) new_m[a] = mag(i_din[a*2*IW + IW +: IW]);
            if (mag(i_din[a*2*IW +: IW]) > new_m[a]) new_m[a] = mag(i_din[a*2*IW +: IW]);
        end
    end

    always_ff @(posedge clk) begin
        if (open_now) mem[cap_bank][wr_idx] <= i_din;
    end

    // Capture side: a PRB only becomes visible downstream once all RE_PER_PRB samples are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_open  <= 1'b0;
            cap_bank  <= 1'b0;
            re_cnt    <= '0;
            calc_pend <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= orphan | sop_err | eop_err;
            calc_pend <= 1'b0;
            if (open_now) begin
                run_m <= new_m;
                if (i_sop) begin
                    cap_meta <= i_meta;
                    cap_en   <= i_comp_en;
                end
                if (eop_err) begin
                    cap_open <= 1'b0;
                    re_cnt   <= '0;
                end else if (last_re) begin
                    cap_open  <= 1'b0;
                    re_cnt    <= '0;
                    cap_bank  <= ~cap_bank;
                    calc_pend <= 1'b1;
                    calc_bank <= cap_bank;
                    calc_eop  <= i_eop;
                    calc_meta <= i_sop ? i_meta : cap_meta;
                    calc_en   <= i_sop ? i_comp_en : cap_en;
                    calc_m    <= new_m;
                end else begin
                    cap_open <= 1'b1;
                    re_cnt   <= wr_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int a = 0; a < NUM_ANT; a++) shift_nxt[a] = calc_en ? shift_of(calc_m[a]) : '0;
    end

    // A freshly computed exponent restarts the drain; it lands exactly as the previous drain ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_act  <= 1'b0;
            drain_bank <= 1'b0;
            drain_eop  <= 1'b0;
            rd_idx     <= '0;
            o_shift    <= '0;
            o_meta     <= '0;
        end else if (calc_pend) begin
            drain_act  <= 1'b1;
            drain_bank <= calc_bank;
            drain_eop  <= calc_eop;
            rd_idx     <= '0;
            o_shift    <= shift_nxt;
            o_meta     <= calc_meta;
        end else if (drain_act) begin
            if (rd_idx == LAST) begin
                drain_act <= 1'b0;
                rd_idx    <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    always_comb begin
        rd_word = mem[drain_bank][rd_idx];
        o_dout  = '0;
        for (int a = 0; a < NUM_ANT; a++) begin
            for (int c = 0; c < 2; c++) begin
                o_dout[a*2*OW + c*OW +: OW] = drain_act ?
                    quant(rd_word[a*2*IW + c*IW +: IW], o_shift[a*SHW +: SHW]) : '0;
            end
        end
    end

    assign o_vld = drain_act;
    assign o_sop = drain_act & (rd_idx == '0);
    assign o_eop = drain_act & drain_eop & (rd_idx == LAST);
    assign o_err = err;

endmodule

// File: tb/tb_ul_bfp_compress_array.sv
// tb/tb_ul_bfp_compress_array.sv - self-checking bench for ul_bfp_compress_array
// Table cases, corner sequences and random PRBs checked against a behavioural PRB model.
module tb_ul_bfp_compress_array;
    localparam int NA  = 4;
    localparam int IW  = 16;
    localparam int OW  = 7;
    localparam int RE  = 12;
    localparam int SHW = 4;
    localparam int MTW = 64;
    localparam int DW  = NA * 2 * IW;
    localparam int OWW = NA * 2 * OW;

    logic clk = 1'b0, rst = 1'b1;
    logic i_vld = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_comp_en = 1'b0;
    logic [DW-1:0]     i_din = '0;
    logic [MTW-1:0]    i_meta = '0;
    logic              o_vld, o_sop, o_eop, o_err;
    logic [OWW-1:0]    o_dout;
    logic [NA*SHW-1:0] o_shift;
    logic [MTW-1:0]    o_meta;

    ul_bfp_compress_array #(.NUM_ANT(NA), .IW(IW), .OW(OW), .RE_PER_PRB(RE), .SHW(SHW), .META_W(MTW)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .i_comp_en(i_comp_en),
        .i_din(i_din), .i_meta(i_meta), .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop),
        .o_dout(o_dout), .o_shift(o_shift), .o_meta(o_meta), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                cyc;
        logic              sop;
        logic              eop;
        logic [OWW-1:0]    dout;
        logic [NA*SHW-1:0] shift;
        logic [MTW-1:0]    meta;
    } exp_t;

    exp_t           eq[$];
    int             err_q[$];
    logic [DW-1:0]  m_buf[$];
    bit             m_open = 0, m_en = 0;
    logic [MTW-1:0] m_meta = '0;
    int             lane_e[NA];

    function automatic int comp(input logic [DW-1:0] d, input int a, input int c);
        logic [IW-1:0] v;
        v = d[a*2*IW + c*IW +: IW];
        return int'($signed(v));
    endfunction

    function automatic int lane_out(input int a, input int c);
        logic [OW-1:0] v;
        v = o_dout[a*2*OW + c*OW +: OW];
        return int'($signed(v));
    endfunction

    // Round half up by s bits using floor division, then saturate to OW bits.
    function automatic int ref_quant(input int x, input int s);
        int num, den, q;
        if (s == 0) q = x;
        else begin
            num = x + (1 << (s - 1));
            den = 1 << s;
            q = num / den;
            if (num < 0 && q * den != num) q = q - 1;
        end
        if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
        if (q < -(1 << (OW - 1))) q = -(1 << (OW - 1));
        return q;
    endfunction

    task automatic m_emit(input int c, input bit eopf);
        int   sh[NA];
        int   m, x, ax, len, y;
        exp_t e;
        for (int a = 0; a < NA; a++) begin
            m = 0;
            for (int k = 0; k < RE; k++)
                for (int cc = 0; cc < 2; cc++) begin
                    x  = comp(m_buf[k], a, cc);
                    ax = (x >= 0) ? x : -x - 1;
                    if (ax > m) m = ax;
                end
            len = 0;
            while ((1 << len) <= m) len++;
            sh[a] = len + 1 - OW;
            if (sh[a] < 0) sh[a] = 0;
            if (sh[a] > (1 << SHW) - 1) sh[a] = (1 << SHW) - 1;
            if (!m_en) sh[a] = 0;
        end
        for (int k = 0; k < RE; k++) begin
            e.cyc  = c + 2 + k;
            e.sop  = (k == 0);
            e.eop  = eopf && (k == RE - 1);
            e.meta = m_meta;
            e.dout = '0;
            for (int a = 0; a < NA; a++) begin
                e.shift[a*SHW +: SHW] = SHW'(sh[a]);
                for (int cc = 0; cc < 2; cc++) begin
                    y = ref_quant(comp(m_buf[k], a, cc), sh[a]);
                    e.dout[a*2*OW + cc*OW +: OW] = OW'(y);
                end
            end
            eq.push_back(e);
        end
    endtask

    task automatic m_step(input bit v, input bit s, input bit e, input bit en,
                          input logic [DW-1:0] d, input logic [MTW-1:0] md);
        bit err;
        err = 0;
        if (v) begin
            if (s) begin
                if (m_open) err = 1;
                m_open = 1;
                m_buf.delete();
                m_meta = md;
                m_en = en;
            end
            if (!m_open) err = 1;
            else begin
                m_buf.push_back(d);
                if (m_buf.size() == RE) begin
                    m_emit(cyc, e);
                    m_open = 0;
                end else if (e) begin
                    err = 1;
                    m_open = 0;
                end
            end
        end
        if (err) err_q.push_back(cyc + 1);
    endtask

    task automatic m_reset();
        exp_t keep[$];
        int   keep_e[$];
        foreach (eq[i]) if (eq[i].cyc <= cyc) keep.push_back(eq[i]);
        foreach (err_q[i]) if (err_q[i] <= cyc) keep_e.push_back(err_q[i]);
        eq = keep;
        err_q = keep_e;
        m_open = 0;
        m_buf.delete();
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input bit e, input bit en,
                         input logic [DW-1:0] d, input logic [MTW-1:0] md);
        rst = r; i_vld = v; i_sop = s; i_eop = e; i_comp_en = en; i_din = d; i_meta = md;
        if (r) m_reset();
        else m_step(v, s, e, en, d, md);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rnd_din();
        logic [DW-1:0] d;
        int v;
        d = '0;
        for (int a = 0; a < NA; a++)
            for (int c = 0; c < 2; c++) begin
                v = int'($urandom_range(0, (1 << lane_e[a]) - 1));
                if ($urandom_range(0, 1) == 1) v = -v - 1;
                d[a*2*IW + c*IW +: IW] = IW'(v);
            end
        return d;
    endfunction

    bit mon_en = 0;
    bit e_err;
    int n_vld, n_sop, n_eop, n_err, first_vld, last_vld;

    task automatic stats_reset();
        n_vld = 0; n_sop = 0; n_eop = 0; n_err = 0; first_vld = -1; last_vld = -1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                chk("o_vld", o_vld, 1);
                chk("o_sop", o_sop, eq[0].sop);
                chk("o_eop", o_eop, eq[0].eop);
                chk("o_dout", o_dout, eq[0].dout);
                chk("o_shift", o_shift, eq[0].shift);
                chk("o_meta", o_meta, eq[0].meta);
                void'(eq.pop_front());
            end else begin
                chk("o_vld_idle", o_vld, 0);
            end
            e_err = (err_q.size() > 0 && err_q[0] == cyc);
            if (e_err) void'(err_q.pop_front());
            chk("o_err", o_err, e_err);
            if (o_vld === 1'b1) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                n_vld++;
            end
            if (o_sop === 1'b1) n_sop++;
            if (o_eop === 1'b1) n_eop++;
            if (o_err === 1'b1) n_err++;
        end
    end

    typedef struct {
        int lane; bit en; bit q1; int v0; int v1; int sh; int y0; int y1;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_done;
        bit seen;
        logic [DW-1:0] d0, d1;

        tbl[0] = '{0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1'b1, 1'b0, 1000, -1000, 4, 63, -62};
        tbl[2] = '{1, 1'b1, 1'b0, 40, -40, 0, 40, -40};
        tbl[3] = '{2, 1'b1, 1'b1, 32767, -32768, 9, 63, -64};
        tbl[4] = '{2, 1'b0, 1'b1, 32767, -32768, 0, 63, -64};
        tbl[5] = '{3, 1'b1, 1'b0, 64, -64, 1, 32, -32};

        stats_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_o_vld", o_vld, 0);
        chk("rst_o_sop", o_sop, 0);
        chk("rst_o_eop", o_eop, 0);
        chk("rst_o_err", o_err, 0);
        chk("rst_o_dout", o_dout, 0);
        chk("rst_o_shift", o_shift, 0);
        chk("rst_o_meta", o_meta, 0);
        @(posedge clk);
        #1;
        mon_en = 1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            d0 = '0;
            d1 = '0;
            d0[tbl[i].lane*2*IW + IW +: IW] = IW'(tbl[i].v0);
            if (tbl[i].q1) d1[tbl[i].lane*2*IW +: IW] = IW'(tbl[i].v1);
            else d1[tbl[i].lane*2*IW + IW +: IW] = IW'(tbl[i].v1);
            stats_reset();
            drive(0, 1, 1, 0, tbl[i].en, d0, 64'(i + 100));
            drive(0, 1, 0, 0, tbl[i].en, d1, '0);
            for (int k = 2; k < RE - 1; k++) drive(0, 1, 0, 0, tbl[i].en, '0, '0);
            t_done = cyc;
            drive(0, 1, 0, 0, tbl[i].en, '0, '0);
            idle(1);
            seen = 0;
            for (int w = 0; w < 20 && !seen; w++) begin
                @(negedge clk);
                seen = (o_vld === 1'b1) && (o_sop === 1'b1);
            end
            chk("tbl_sop_seen", seen, 1);
            if (seen) begin
                chk("tbl_sop_cycle", cyc, t_done + 2);
                chk("tbl_shift", o_shift[tbl[i].lane*SHW +: SHW], tbl[i].sh);
                chk("tbl_y0", lane_out(tbl[i].lane, 1), tbl[i].y0);
                @(negedge clk);
                chk("tbl_y1", lane_out(tbl[i].lane, tbl[i].q1 ? 0 : 1), tbl[i].y1);
            end
            @(posedge clk);
            #1;
            idle(14);
            chk("tbl_vld_count", n_vld, RE);
        end

        // Three back-to-back PRBs, eop on the 36th RE.
        stats_reset();
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < NA; a++) lane_e[a] = $urandom_range(0, 15);
            for (int k = 0; k < RE; k++)
                drive(0, 1, k == 0, (p == 2) && (k == RE - 1), 1, rnd_din(), {$urandom, $urandom});
        end
        idle(20);
        chk("b2b_vld_count", n_vld, 3 * RE);
        chk("b2b_gap_free", last_vld - first_vld, 3 * RE - 1);
        chk("b2b_sop_count", n_sop, 3);
        chk("b2b_eop_count", n_eop, 1);
        chk("b2b_err_count", n_err, 0);

        // Early sop after 5 REs, a clean PRB, then eop on RE 7.
        stats_reset();
        for (int k = 0; k < 5; k++) drive(0, 1, k == 0, 0, 1, rnd_din(), 64'h55);
        for (int k = 0; k < RE; k++) drive(0, 1, k == 0, 0, 1, rnd_din(), 64'h66);
        for (int k = 0; k < 7; k++) drive(0, 1, k == 0, k == 6, 1, rnd_din(), 64'h77);
        idle(20);
        chk("frm_err_count", n_err, 2);
        chk("frm_vld_count", n_vld, RE);

        // Reset while PRB0 drains RE 6 and PRB1 is half captured.
        stats_reset();
        for (int k = 0; k < RE; k++) drive(0, 1, k == 0, 0, 1, rnd_din(), 64'hA0);
        for (int k = 0; k < 7; k++) drive(0, 1, k == 0, 0, 1, rnd_din(), 64'hA1);
        drive(1, 0, 0, 0, 0, '0, '0);
        idle(20);
        chk("rst_drain_vld_count", n_vld, 7);
        stats_reset();
        for (int k = 0; k < RE - 1; k++) drive(0, 1, k == 0, 0, 1, rnd_din(), 64'hA2);
        t_done = cyc;
        drive(0, 1, 0, 0, 1, rnd_din(), '0);
        idle(16);
        chk("post_rst_first_vld", first_vld, t_done + 2);
        chk("post_rst_vld_count", n_vld, RE);

        // Random PRBs with varied exponents, gaps, comp_en and occasional framing errors.
        for (int p = 0; p < 40; p++) begin
            int n;
            bit en, eopf, trunc;
            for (int a = 0; a < NA; a++) lane_e[a] = $urandom_range(0, 15);
            en = ($urandom_range(0, 4) != 0);
            trunc = ($urandom_range(0, 7) == 0);
            n = trunc ? int'($urandom_range(1, RE - 1)) : RE;
            eopf = trunc ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) idle(1);
                drive(0, 1, k == 0, eopf && (k == n - 1), en, rnd_din(), {$urandom, $urandom});
            end
        end
        idle(30);
        chk("exp_queue_drained", eq.size(), 0);
        chk("err_queue_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
